e_mdu_ctrl: RTL and testbench

// - Multi-cycle multiply/divide sequencer in the E stage, alongside the single-cycle ALU.
// - Executes mult/multu/div/divu over a fixed number of cycles, owns the HI/LO registers and

---
 rtl/e_mdu_ctrl_pkg.sv | 32 +++
 rtl/e_mdu_ctrl_calc.sv | 85 ++++++++
 rtl/e_mdu_ctrl.sv | 120 ++++++++++++
 tb/tb_e_mdu_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit:
// opcode encodings, sequencer states and the latched request bundle.
package e_mdu_ctrl_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } mdu_req_t;

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_calc.sv
// Result datapath: turns the latched request into HI/LO values
// plus a write enable that is dropped on divide by zero.
module e_mdu_ctrl_calc
    import e_mdu_ctrl_pkg::*;
(
    input  mdu_req_t    req_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wr_o
);

    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] sdiv;
    logic [31:0] udiv;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        b_zero;

    always_comb begin
        sa    = {{32{req_i.a[31]}}, req_i.a};
        sb    = {{32{req_i.b[31]}}, req_i.b};
        ua    = {32'b0, req_i.a};
        ub    = {32'b0, req_i.b};
        sprod = sa * sb;
        uprod = ua * ub;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally.
    always_comb begin
        b_zero = (req_i.b == 32'd0);
        mag_a  = req_i.a[31] ? (32'd0 - req_i.a) : req_i.a;
        mag_b  = req_i.b[31] ? (32'd0 - req_i.b) : req_i.b;
        sdiv   = b_zero ? 32'd1 : mag_b;
        udiv   = b_zero ? 32'd1 : req_i.b;
        sq_mag = mag_a / sdiv;
        sr_mag = mag_a % sdiv;
        sq     = (req_i.a[31] ^ req_i.b[31]) ? (32'd0 - sq_mag) : sq_mag;
        sr     = req_i.a[31] ? (32'd0 - sr_mag) : sr_mag;
        uq     = req_i.a / udiv;
        ur     = req_i.a % udiv;
    end

    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        wr_o = 1'b0;
        unique case (req_i.op)
            MDU_MULT: begin
                hi_o = sprod[63:32];
                lo_o = sprod[31:0];
                wr_o = 1'b1;
            end
            MDU_MULTU: begin
                hi_o = uprod[63:32];
                lo_o = uprod[31:0];
                wr_o = 1'b1;
            end
            MDU_DIV: begin
                hi_o = sr;
                lo_o = sq;
                wr_o = !b_zero;
            end
            MDU_DIVU: begin
                hi_o = ur;
                lo_o = uq;
                wr_o = !b_zero;
            end
            default: begin
                wr_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multi-cycle multiply/divide sequencer owning HI/LO;
// busy stalls later MDU ops, mf/mt moves complete with zero latency.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    mdu_req_t      req_q, req_d;

    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_wr;

    e_mdu_ctrl_calc u_calc (
        .req_i (req_q),
        .hi_o  (res_hi),
        .lo_o  (res_lo),
        .wr_o  (res_wr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        req_d   = req_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mult_op(mdu_op) || is_div_op(mdu_op)) begin
                        req_d.op = mdu_op;
                        req_d.a  = A;
                        req_d.b  = B;
                        cnt_d    = is_mult_op(mdu_op) ? CW'(MULT_CYCLES)
                                                      : CW'(DIV_CYCLES);
                        busy_d   = 1'b1;
                        state_d  = S_BUSY;
                    end else if (mdu_op == MDU_MTHI) begin
                        hi_d = A;
                    end else if (mdu_op == MDU_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_BUSY: begin
                // Starts are ignored here; the hazard unit owns stalling.
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        out = 32'd0;
        if (mdu_op == MDU_MFHI) begin
            out = hi_q;
        end else if (mdu_op == MDU_MFLO) begin
            out = lo_q;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: long ops queue expected HI/LO and
// busy length; a negedge monitor checks them when busy falls.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = MDU_NONE;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    e_mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .out    (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail = 0;
    logic busy_prev = 1'b0;
    int   blen = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void expect_res(string nm, logic [31:0] h, logic [31:0] l, int len);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.len = len;
        e.name = nm;
        sbq.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            busy_prev = 1'b0;
            blen = 0;
        end else begin
            if (busy_prev && !busy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur = sbq.pop_front();
                    chk({cur.name, "_hi"}, hi, cur.hi);
                    chk({cur.name, "_lo"}, lo, cur.lo);
                    chk({cur.name, "_busylen"}, 32'(blen), 32'(cur.len));
                end
                blen = 0;
            end
            if (busy) blen++;
            busy_prev = busy;
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        mdu_op = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdu_op = MDU_NONE;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        drive(op, a, b);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mdu_op = MDU_MFHI;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_out", out, 32'd0);
        mdu_op = MDU_NONE;
        reset = 1'b1;

        expect_res("mult", 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        issue(MDU_MULT, 32'hFFFFFFFD, 32'd5);
        chk("mult_busy", 32'(busy), 32'd1);
        wait_idle();

        expect_res("multu", 32'h00000001, 32'hFFFFFFFE, 5);
        issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
        wait_idle();

        expect_res("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        expect_res("divu", 32'd1, 32'd3, 10);
        issue(MDU_DIVU, 32'd7, 32'd2);
        wait_idle();

        expect_res("div_ovf", 32'd0, 32'h80000000, 10);
        issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        issue(MDU_MTHI, 32'h1234, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_lo_kept", lo, 32'h80000000);
        mdu_op = MDU_MFHI;
        #1;
        chk("mfhi_out", out, 32'h1234);
        mdu_op = MDU_NONE;
        #1;
        chk("none_out", out, 32'd0);

        issue(MDU_MTLO, 32'h5678, 32'd0);
        mdu_op = MDU_MFLO;
        #1;
        chk("mflo_out", out, 32'h5678);
        mdu_op = MDU_NONE;

        expect_res("divu_zero", 32'h1234, 32'h5678, 10);
        issue(MDU_DIVU, 32'd99, 32'd0);
        wait_idle();

        expect_res("mult_first", 32'd0, 32'd12, 5);
        issue(MDU_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        drive(MDU_MULT, 32'd7, 32'd7);
        A = 32'hA5A5A5A5;
        B = 32'h5A5A5A5A;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_start_busy", 32'(busy), 32'd0);

        expect_res("b2b_a", 32'd0, 32'd6, 5);
        expect_res("b2b_b", 32'hFFFFFFFE, 32'h00000001, 5);
        issue(MDU_MULT, 32'd2, 32'd3);
        wait_idle();
        drive(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_idle();
        mdu_op = MDU_MFHI;
        #1;
        chk("b2b_mfhi", out, 32'hFFFFFFFE);
        mdu_op = MDU_NONE;

        issue(4'hF, 32'hDEADBEEF, 32'd1);
        chk("undef_busy", 32'(busy), 32'd0);
        chk("undef_hi", hi, 32'hFFFFFFFE);
        chk("undef_lo", lo, 32'h00000001);

        issue(MDU_DIV, 32'd100, 32'd3);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
